// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB slave among NUM_REQ requesters.
// Drives SETUP/ACCESS, honours PREADY wait states, bounds each transfer with a timeout.
module apb_master_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                              PCLK,
  input  logic                              PRESET,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_strb,
  output logic [NUM_REQ-1:0]                req_done,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              rsp_err,
  output logic                              rsp_timeout,
  output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
  output logic [ADDR_WIDTH-1:0]             PADDR,
  output logic                              PWRITE,
  output logic [DATA_WIDTH-1:0]             PWDATA,
  output logic [DATA_WIDTH/8-1:0]           PSTRB,
  output logic                              PSEL,
  output logic                              PENABLE,
  input  logic [DATA_WIDTH-1:0]             PRDATA,
  input  logic                              PREADY,
  input  logic                              PSLVERR
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int CW  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t         r_state;
  logic [IDW-1:0] r_last_grant;
  logic [IDW-1:0] r_grant;
  logic [CW-1:0]  r_wait;

  logic           w_any;
  logic [IDW-1:0] w_pick;
  logic [IDW-1:0] w_cand;

  // First pending requester found scanning upward from last_grant+1, wrapping.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_last_grant;
    w_cand = r_last_grant;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_cand = IDW'((32'(r_last_grant) + i) % NUM_REQ);
      if (!w_any && req_valid[w_cand]) begin
        w_any  = 1'b1;
        w_pick = w_cand;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state      <= IDLE;
      r_last_grant <= IDW'(NUM_REQ - 1);
      r_grant      <= '0;
      r_wait       <= '0;
      req_done     <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      rsp_timeout  <= 1'b0;
      rsp_id       <= '0;
      PADDR        <= '0;
      PWRITE       <= 1'b0;
      PWDATA       <= '0;
      PSTRB        <= '0;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
    end else begin
      req_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            PADDR        <= req_addr[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
            PWRITE       <= req_write[w_pick];
            PWDATA       <= req_wdata[w_pick*DATA_WIDTH +: DATA_WIDTH];
            PSTRB        <= req_write[w_pick] ? req_strb[w_pick*SW +: SW] : '0;
            PSEL         <= 1'b1;
            r_state      <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          r_wait  <= '0;
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            req_done[r_grant] <= 1'b1;
            if (!PWRITE) rsp_rdata <= PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_id      <= r_grant;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            r_state     <= IDLE;
          end else if (r_wait == CW'(TIMEOUT_CYCLES - 1)) begin
            req_done[r_grant] <= 1'b1;
            rsp_rdata   <= '1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_id      <= r_grant;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: latency, round-robin order, wait states,
// slave error, timeout and mid-transfer reset, with hand-computed expectations.
module tb_apb_master_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [1:0]  req_valid, req_write;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_strb;
  logic [1:0]  req_done;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [0:0]  rsp_id;
  logic [7:0]  PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;

  int n_vec  = 0;
  int n_miss = 0;

  apb_master_arbiter #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REQ(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_done(req_done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .rsp_id(rsp_id), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one transfer; slave inserts `waits` PREADY-low ACCESS cycles.
  task automatic do_xfer(input int id, input logic wr, input logic [7:0] a,
                         input logic [31:0] wd, input logic [3:0] st, input int waits,
                         input logic [31:0] rd, input logic err,
                         output int lat, output int acc);
    int  bad;
    bit  seen;
    req_write[id]          = wr;
    req_addr[id*8 +: 8]    = a;
    req_wdata[id*32 +: 32] = wd;
    req_strb[id*4 +: 4]    = st;
    req_valid[id]          = 1'b1;
    PRDATA  = rd;
    PSLVERR = err;
    PREADY  = 1'b0;
    lat = 0; acc = 0; bad = 0; seen = 0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (req_done[id]) begin
        seen          = 1;
        req_valid[id] = 1'b0;
        PREADY        = 1'b0;
      end else if (PSEL && PENABLE) begin
        if (PADDR !== a || PWRITE !== wr || PWDATA !== wd || PSTRB !== (wr ? st : 4'h0))
          bad++;
        PREADY = (acc >= waits);
        acc++;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    check("apb_stable", 64'(bad), 64'd0);
  endtask

  int lat, acc, n, cyc, c0, c1;

  initial begin
    PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    req_strb = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick(); tick();
    check("rst_psel", 64'(PSEL), 0);
    check("rst_penable", 64'(PENABLE), 0);
    check("rst_done", 64'(req_done), 0);
    check("rst_paddr", 64'(PADDR), 0);
    check("rst_rdata", 64'(rsp_rdata), 0);
    check("rst_err", 64'({rsp_err, rsp_timeout, rsp_id}), 0);
    PRESET = 1'b0;

    // Write then read, zero wait states
    do_xfer(0, 1'b1, 8'h05, 32'hCAFEBABE, 4'hF, 0, 32'h0, 1'b0, lat, acc);
    check("wr_lat", 64'(lat), 3);
    check("wr_rdata_kept", 64'(rsp_rdata), 0);
    check("wr_err", 64'(rsp_err), 0);
    tick();
    check("done_one_cycle", 64'(req_done), 0);
    do_xfer(0, 1'b0, 8'h05, 32'h0, 4'hF, 0, 32'hCAFEBABE, 1'b0, lat, acc);
    check("rd_lat", 64'(lat), 3);
    check("rd_rdata", 64'(rsp_rdata), 64'hCAFEBABE);
    check("rd_err", 64'(rsp_err), 0);
    check("rd_id", 64'(rsp_id), 0);

    // Three wait states on requester 1
    do_xfer(1, 1'b0, 8'h20, 32'h0, 4'h3, 3, 32'h12345678, 1'b0, lat, acc);
    check("ws_lat", 64'(lat), 6);
    check("ws_access_cycles", 64'(acc), 4);
    check("ws_rdata", 64'(rsp_rdata), 64'h12345678);
    check("ws_id", 64'(rsp_id), 1);

    // Slave error
    do_xfer(0, 1'b0, 8'hFF, 32'h0, 4'h0, 0, 32'hDEAD0000, 1'b1, lat, acc);
    check("se_lat", 64'(lat), 3);
    check("se_flags", 64'({rsp_err, rsp_timeout}), 64'b10);
    check("se_rdata", 64'(rsp_rdata), 64'hDEAD0000);
    PSLVERR = 1'b0;

    // Timeout: PREADY never rises; 16 ACCESS cycles, done 2+16 edges after grant
    do_xfer(1, 1'b1, 8'h33, 32'hA5A5A5A5, 4'h5, 1000, 32'h0, 1'b0, lat, acc);
    check("to_access_cycles", 64'(acc), 16);
    check("to_lat", 64'(lat), 18);
    check("to_flags", 64'({rsp_err, rsp_timeout}), 64'b11);
    check("to_rdata", 64'(rsp_rdata), 64'hFFFFFFFF);
    check("to_id", 64'(rsp_id), 1);
    check("to_idle", 64'({PSEL, PENABLE}), 0);
    tick();
    check("to_still_idle", 64'(PSEL), 0);

    // Contention after reset: strict 0,1 alternation, one idle cycle between transfers
    PRESET = 1'b1; tick(); PRESET = 1'b0;
    req_write = 2'b00; req_addr = 16'h2211; req_strb = 8'h00;
    PREADY = 1'b1; PRDATA = 32'h0BADF00D;
    req_valid = 2'b11;
    n = 0; cyc = 0; c0 = 0; c1 = 0;
    while (n < 8 && cyc < 100) begin
      tick(); cyc++;
      if (req_done != 2'b00) begin
        check("cont_done", 64'(req_done), (n % 2) ? 64'd2 : 64'd1);
        check("cont_id", 64'(rsp_id), 64'(n % 2));
        if (n % 2 == 0) begin c0++; if (c0 == 4) req_valid[0] = 1'b0; end
        else begin c1++; if (c1 == 4) req_valid[1] = 1'b0; end
        n++;
        if (n < 8) begin
          check("gap_psel_low", 64'(PSEL), 0);
          tick(); cyc++;
          check("gap_psel_high", 64'(PSEL), 1);
        end
      end
    end
    check("cont_count", 64'(n), 8);
    PREADY = 1'b0;
    tick();

    // Reset mid-ACCESS: req0 in flight (last grant 0), then req1 would normally win next
    req_addr[7:0] = 8'h44; req_write[0] = 1'b0; req_valid = 2'b01;
    cyc = 0;
    while (!(PSEL && PENABLE) && cyc < 10) begin tick(); cyc++; end
    check("mr_reached_access", 64'(PENABLE), 1);
    PRESET = 1'b1; req_valid = 2'b00;
    tick();
    check("mr_psel_pen", 64'({PSEL, PENABLE}), 0);
    check("mr_no_done", 64'(req_done), 0);
    check("mr_outs", 64'({PADDR, PSTRB, PWRITE, rsp_err, rsp_timeout, rsp_id}), 0);
    check("mr_rdata", 64'(rsp_rdata), 0);
    PRESET = 1'b0; PREADY = 1'b1; req_valid = 2'b11;
    cyc = 0;
    while (req_done == 2'b00 && cyc < 10) begin tick(); cyc++; end
    check("mr_first_done", 64'(req_done), 1);
    check("mr_first_id", 64'(rsp_id), 0);
    req_valid = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
